// File: rtl/pll_reconfig_ctrl_if.sv
// Request/status bundle between the clock-management client and pll_reconfig_ctrl.
// The client (master) offers a new divider set; the controller (slave) reports lock state.
interface pll_reconfig_ctrl_if;
  logic       cfg_req;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic [5:0] cfg_odsel;
  logic [3:0] cfg_psda;
  logic [3:0] cfg_dutyda;
  logic       cfg_ready;
  logic       locked;
  logic       err;
  logic       lock_lost;

  modport master (
    output cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda,
    input  cfg_ready, locked, err, lock_lost
  );

  modport slave (
    input  cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda,
    output cfg_ready, locked, err, lock_lost
  );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Reset-and-relock sequencer for the GW1NR-9 rPLL dynamic configuration port.
// Holds the PLL in reset, waits for a qualified lock, and reports a debounced locked flag.
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         STABLE_CYCLES = 1024,
  parameter int         LOCK_TIMEOUT  = 65536,
  parameter logic [5:0] DEF_IDSEL     = 6'h00,
  parameter logic [5:0] DEF_FBDSEL    = 6'h00,
  parameter logic [5:0] DEF_ODSEL     = 6'h00,
  parameter logic [3:0] DEF_PSDA      = 4'h0,
  parameter logic [3:0] DEF_DUTYDA    = 4'h8
) (
  input  logic               clk,
  input  logic               rst_n,
  pll_reconfig_ctrl_if.slave cfg,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic [5:0]         pll_idsel,
  output logic [5:0]         pll_fbdsel,
  output logic [5:0]         pll_odsel,
  output logic [3:0]         pll_psda,
  output logic [3:0]         pll_dutyda
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {ST_RST, ST_WAIT, ST_QUAL, ST_LOCKED, ST_ERROR} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      lock_sync;
  logic            lock_s;
  logic            accept;
  logic            drop;
  logic [RW-1:0]   rst_cnt;
  logic [SW-1:0]   stb_cnt;
  logic [TW-1:0]   to_cnt;
  logic            locked_q;
  logic            ready_q;
  logic            err_q;
  logic            lost_q;

  assign lock_s        = lock_sync[1];
  assign cfg.cfg_ready = ready_q;
  assign cfg.locked    = locked_q;
  assign cfg.err       = err_q;
  assign cfg.lock_lost = lost_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
    end
  end

  // A request landing on the same edge as a lock drop still wins; drop only flags lock_lost.
  always_comb begin
    state_d = state_q;
    accept  = cfg.cfg_req && (state_q == ST_LOCKED || state_q == ST_ERROR);
    drop    = 1'b0;
    case (state_q)
      ST_RST: begin
        if (rst_cnt == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (to_cnt == TO_LAST) state_d = ST_ERROR;
        else if (lock_s)       state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (lock_s && stb_cnt == STB_LAST) state_d = ST_LOCKED;
        else if (to_cnt == TO_LAST)        state_d = ST_ERROR;
        else if (!lock_s)                  state_d = ST_WAIT;
      end
      ST_LOCKED: begin
        drop = !lock_s;
        if (accept || !lock_s) state_d = ST_RST;
      end
      ST_ERROR: begin
        if (accept) state_d = ST_RST;
      end
      default: state_d = ST_RST;
    endcase
  end

  // Counters are cleared on state entry and saturate at their terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      rst_cnt <= '0;
      stb_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_RST && state_q != ST_RST) rst_cnt <= '0;
      else if (state_q == ST_RST && rst_cnt != RST_LAST) rst_cnt <= rst_cnt + RW'(1);
      if (state_d == ST_QUAL && state_q != ST_QUAL) stb_cnt <= '0;
      else if (state_q == ST_QUAL && lock_s && stb_cnt != STB_LAST) stb_cnt <= stb_cnt + SW'(1);
      if (state_q == ST_RST) to_cnt <= '0;
      else if ((state_q == ST_WAIT || state_q == ST_QUAL) && to_cnt != TO_LAST) to_cnt <= to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset  <= 1'b1;
      locked_q   <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      lost_q     <= 1'b0;
      pll_idsel  <= DEF_IDSEL;
      pll_fbdsel <= DEF_FBDSEL;
      pll_odsel  <= DEF_ODSEL;
      pll_psda   <= DEF_PSDA;
      pll_dutyda <= DEF_DUTYDA;
    end else begin
      pll_reset <= (state_d == ST_RST) || (state_d == ST_ERROR);
      locked_q  <= (state_d == ST_LOCKED);
      ready_q   <= (state_d == ST_LOCKED) || (state_d == ST_ERROR);
      lost_q    <= drop;
      if (accept)                 err_q <= 1'b0;
      else if (state_d == ST_ERROR) err_q <= 1'b1;
      if (accept) begin
        pll_idsel  <= cfg.cfg_idsel;
        pll_fbdsel <= cfg.cfg_fbdsel;
        pll_odsel  <= cfg.cfg_odsel;
        pll_psda   <= cfg.cfg_psda;
        pll_dutyda <= cfg.cfg_dutyda;
      end
    end
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer for the GW1NR-9 rPLL's dynamic configuration port. It runs in the crystal-input clock domain and drives the PLL's RESET, IDSEL, FBDSEL, ODSEL, PSDA and DUTYDA inputs. It performs a clean reset-and-relock whenever a new divider set is requested or lock is lost. It publishes a debounced `locked` flag that the PDP-11 core clock-enable and bus-interface logic use to stay idle until the generated clock is stable.

## Interface
- RST_CYCLES, 16: cycles `pll_reset` is held high per relock attempt (≥2).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before `locked` asserts (≥1).
- LOCK_TIMEOUT, 65536: cycles after reset release allowed to qualify lock before error (> STABLE_CYCLES).
- DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL, 6'h00 each: raw select codes loaded at reset.
- DEF_PSDA, 4'h0; DEF_DUTYDA, 4'h8: phase and duty codes loaded at reset.
- clk  in  1  crystal/PLL input clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_req  in  1  one-cycle request to apply the `cfg_*` codes; honoured only while `cfg_ready`=1.
- cfg_idsel, cfg_fbdsel, cfg_odsel  in  6 each  new raw select codes.
- cfg_psda, cfg_dutyda  in  4 each  new phase and duty codes.
- cfg_ready  out  1  controller is in LOCKED or ERROR and accepts `cfg_req`.
- locked  out  1  qualified lock.
- err  out  1  last attempt timed out; sticky until the next accepted `cfg_req`.
- lock_lost  out  1  one-cycle pulse when lock drops while in LOCKED.
- pll_lock  in  1  raw PLL LOCK; asynchronous to `clk`.
- pll_reset  out  1  to PLL RESET.
- pll_idsel, pll_fbdsel, pll_odsel  out  6 each  registered select codes.
- pll_psda, pll_dutyda  out  4 each  registered phase and duty codes.

## Operation
- Synchronizer: `pll_lock` passes through 2 flip-flops to produce `lock_s`. Only `lock_s` is used.
- **States:**
  - RST: `pll_reset`=1. A counter runs 0..RST_CYCLES-1. After the last count the FSM enters WAIT and clears the timeout counter.
  - WAIT: `pll_reset`=0, timeout counter increments. `lock_s`=1 moves to QUAL with the stable counter cleared.
  - QUAL: the stable counter increments while `lock_s`=1. `lock_s`=0 returns to WAIT; the stable counter clears and the timeout counter does not. When the stable counter reaches STABLE_CYCLES-1 with `lock_s`=1, the FSM enters LOCKED.
  - LOCKED: `locked`=1, `cfg_ready`=1.
    - `lock_s`=0 pulses `lock_lost`, drops `locked` and enters RST with unchanged codes.
    - Accepted `cfg_req` latches all five `cfg_*` codes into the `pll_*` registers, clears `err` and enters RST.
    - If `lock_s` falls and `cfg_req` is accepted in the same cycle, the request wins: codes load and `lock_lost` still pulses.
  - ERROR: `pll_reset`=1, `err`=1, `cfg_ready`=1. Exits only on an accepted `cfg_req` (load codes, clear `err`, enter RST).
- Timeout: the timeout counter runs across WAIT and QUAL. If it reaches LOCK_TIMEOUT-1 before LOCKED, the FSM enters ERROR.
- `cfg_req` while `cfg_ready`=0 is ignored and not queued.
- The `pll_*` code registers change only on an accepted request or on reset, never mid-sequence.
- Counter widths are $clog2(param)+1. Counters saturate; none wraps.

## Timing
- **Reset values:** state=RST (counter 0), `pll_reset`=1, `locked`=0, `cfg_ready`=0, `err`=0, `lock_lost`=0, `pll_*` = DEF_* values.
- **Reset deassertion:** the full sequence starts automatically. `pll_reset` stays high for RST_CYCLES cycles after the first clock edge with `rst_n`=1.
- **Accepted `cfg_req` at edge N:**
  - New codes are visible and `pll_reset`=1 at N+1.
  - `pll_reset` is high for edges N+1..N+RST_CYCLES.
- **Minimum request-to-`locked` latency:** RST_CYCLES + 2 (synchronizer) + STABLE_CYCLES + 1 cycles.
- **Lock loss:** `lock_lost` and `locked`=0 appear 1 cycle after `lock_s` falls, i.e. 3 cycles after `pll_lock` falls.
- **`rst_n` low mid-sequence:** all state returns to reset values immediately and asynchronously. Any in-progress configuration is discarded, not retained.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=64.
- **Power-up:** release `rst_n`; the PLL model raises lock 10 cycles after `pll_reset` falls.
  - Required: `pll_reset` high exactly 4 cycles.
  - Required: `locked`=1 exactly 2+8+1 cycles after `pll_lock` rises.
  - Required: `pll_idsel`=DEF_IDSEL.
- **Reconfigure:** in LOCKED, pulse `cfg_req` with idsel=6'h3A, odsel=6'h30.
  - Required: codes appear next cycle with `pll_reset`=1 and `locked`=0.
  - Required: relock follows, and codes are unchanged throughout the sequence.
- **Glitchy lock:** in QUAL, drop `pll_lock` for 1 cycle after 5 stable cycles.
  - Required: the stable count restarts.
  - Required: `locked` asserts only after 8 further consecutive lock cycles.
- **Timeout:** hold `pll_lock`=0.
  - Required: ERROR 64 cycles after `pll_reset` falls, with `err`=1, `pll_reset`=1, `cfg_ready`=1.
  - Then apply `cfg_req`: required `err`=0 and RST entered.
- **Lock loss:** in LOCKED, drop `pll_lock`.
  - Required: one-cycle `lock_lost` 3 cycles later, followed by a relock sequence with the same codes.
  - `cfg_req` applied during RST is ignored.
- **Async reset mid-QUAL:** required immediate return of all outputs to reset values, including `pll_*`=DEF_*.
